multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Moore-style main control FSM for the multi-cycle datapath. It sequences each instruction through fetch, decode, execute, memory and writeback. It is the producer of the 4-bit ALU operation code and the consumer of the ALU `zero` flag, and drives every datapath mux select and write enable. It stalls on a memory-ready handshake and counts retired instructions.

## Interface
Parameters:
- `CNT_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `opcode` in 6: instruction register bits [31:26].
- `funct` in 6: instruction register bits [5:0].
- `zero` in 1: ALU zero flag, valid during the BRANCH state.
- `memReady` in 1: memory completes the current access this cycle.
- `aluCtr` out 4: ALU operation. Codes: 0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt.
- `aluSrcA` out 1: ALU operand A select; 0 = PC, 1 = register A.
- `aluSrcB` out 2: ALU operand B select; 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
- `iorD` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `memRead` out 1: memory read strobe.
- `memWrite` out 1: memory write strobe.
- `irWrite` out 1: instruction register load enable.
- `regDst` out 1: destination register select; 1 = rd, 0 = rt.
- `memToReg` out 1: writeback data select; 1 = MDR, 0 = ALUOut.
- `regWrite` out 1: register file write enable.
- `pcWrite` out 1: unconditional PC load.
- `pcWriteCond` out 1: PC load when `zero` = 1.
- `pcSource` out 2: next-PC select; 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `instrDone` out 1: one-cycle pulse when an instruction retires.
- `illegal` out 1: one-cycle pulse when an unsupported opcode or funct is decoded.
- `retired` out `CNT_W`: count of retired instructions.
- `state` out 4: current FSM state, for debug.

## Operation
- States and encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, ALU_WB=7, BRANCH=8, JUMP=9. Encodings 10–15 are unreachable; if entered, the next state is FETCH.
- FETCH:
  - Outputs: memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluCtr=0010, pcSource=00.
  - irWrite and pcWrite equal `memReady`.
  - Stays in FETCH until `memReady`=1, then goes to DECODE.
- DECODE:
  - Outputs: aluSrcA=0, aluSrcB=11, aluCtr=0010 (precomputes the branch target).
  - Next state by opcode: 100011 (lw) or 101011 (sw) → MEM_ADDR; 000000 (R-type) → EXECUTE; 000100 (beq) → BRANCH; 000010 (j) → JUMP.
  - Supported R-type funct values: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - Any other opcode, or an R-type with any other funct: `illegal`=1 for this cycle, next state FETCH, no retire.
- MEM_ADDR: aluSrcA=1, aluSrcB=10, aluCtr=0010. Next state MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: memRead=1, iorD=1. Waits for `memReady`, then goes to MEM_WB.
- MEM_WB: regWrite=1, memToReg=1, regDst=0. Retires, then goes to FETCH.
- MEM_WRITE: memWrite=1, iorD=1. Waits for `memReady`; on that cycle it retires and goes to FETCH.
- EXECUTE: aluSrcA=1, aluSrcB=00, aluCtr decoded from funct (add→0010, sub→0110, and→0000, or→0001, slt→0111). Next state ALU_WB.
- ALU_WB: regWrite=1, regDst=1, memToReg=0. Retires, then goes to FETCH.
- BRANCH: aluSrcA=1, aluSrcB=00, aluCtr=0110, pcWriteCond=1, pcSource=01. Retires, then goes to FETCH; the branch is taken or not by the datapath.
- JUMP: pcWrite=1, pcSource=10. Retires, then goes to FETCH.
- All outputs not listed for a state are 0. Exception: `aluCtr` is 0010 wherever it is not listed.
- Retire: `instrDone`=1 for that cycle, and `retired` increments on the same edge. `retired` wraps modulo 2^CNT_W without saturating.

## Timing
- Reset, sampled at a rising edge:
  - state ← FETCH, `retired` ← 0.
  - While `reset`=1, every enable and strobe (memRead, memWrite, irWrite, regWrite, pcWrite, pcWriteCond, instrDone, illegal) is forced to 0. Selects hold their FETCH values.
  - A reset asserted mid-instruction aborts the instruction; there is no retire and no write.
- Outputs are combinational from `state` (plus `funct` in EXECUTE and `memReady` in FETCH). There are no registered outputs.
- Cycle counts with zero-wait memory: lw 5, sw 4, R-type 4, beq 3, j 3, illegal 2.
- Each cycle with `memReady`=0 in FETCH, MEM_READ or MEM_WRITE adds one cycle.
- During a stall, strobes stay asserted and the address selects do not change.
- `memReady` is ignored in every other state.
- `opcode` and `funct` must remain stable from DECODE through retire; the IR guarantees this.

## Structure
- Shared package `cpu_pkg` holds:
  - the state enum;
  - ALU op constants ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT;
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J;
  - funct constants.
- One natural sub-module, `alu_op_decode`: combinational funct → 4-bit aluCtr plus a valid flag. DECODE uses the flag for illegal detection; EXECUTE uses the code.

## Test plan
- Reset held 3 cycles, then released with `memReady`=1 and opcode 000000, funct 100010 → state sequence 0,1,6,7,0; aluCtr=0110 in EXECUTE; regWrite=1 and regDst=1 in ALU_WB; `retired`=1.
- lw (100011) with `memReady` low for 2 cycles in MEM_READ → sequence 0,1,2,3,3,3,4,0; memRead and iorD stay 1 throughout the stall; exactly one regWrite pulse with memToReg=1.
- sw (101011) with `memReady` low for 1 cycle in FETCH → irWrite and pcWrite are 0 in the stall cycle and 1 in the ready cycle; memWrite=1 in MEM_WRITE only; no regWrite.
- beq (000100) → BRANCH with pcWriteCond=1, pcSource=01, aluCtr=0110; `instrDone` pulses once.
- opcode 111111, then R-type with funct 000000 → `illegal` pulses in DECODE each time, return to FETCH, `retired` unchanged.
- `reset` asserted during MEM_WRITE → memWrite drops to 0 in the reset cycle, state=FETCH next, `retired`=0; counter preloaded near 2^CNT_W−1 wraps to 0 on the next retire.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle controller: FSM states, ALU codes,
// opcodes and R-type funct values.
package cpu_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle. The controller takes the master side,
// the datapath (or a bench standing in for it) the slave side.
interface multicycle_ctrl_if #(parameter int CNT_W = 32);

  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             zero;
  logic             memReady;
  logic [3:0]       aluCtr;
  logic             aluSrcA;
  logic [1:0]       aluSrcB;
  logic             iorD;
  logic             memRead;
  logic             memWrite;
  logic             irWrite;
  logic             regDst;
  logic             memToReg;
  logic             regWrite;
  logic             pcWrite;
  logic             pcWriteCond;
  logic [1:0]       pcSource;
  logic             instrDone;
  logic             illegal;
  logic [CNT_W-1:0] retired;
  logic [3:0]       state;

  modport master (
    input  opcode, funct, zero, memReady,
    output aluCtr, aluSrcA, aluSrcB, iorD, memRead, memWrite, irWrite,
           regDst, memToReg, regWrite, pcWrite, pcWriteCond, pcSource,
           instrDone, illegal, retired, state
  );

  modport slave (
    output opcode, funct, zero, memReady,
    input  aluCtr, aluSrcA, aluSrcB, iorD, memRead, memWrite, irWrite,
           regDst, memToReg, regWrite, pcWrite, pcWriteCond, pcSource,
           instrDone, illegal, retired, state
  );

endinterface

// File: rtl/multicycle_ctrl_alu_op_decode.sv
// R-type funct to ALU operation; valid flags the supported funct set.
module alu_op_decode
  import cpu_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_ctr,
  output logic       valid
);

  // funct lookup; unsupported values fall back to add and clear valid
  always_comb begin
    alu_ctr = ALU_ADD;
    valid   = 1'b1;
    case (funct)
      FN_ADD:  alu_ctr = ALU_ADD;
      FN_SUB:  alu_ctr = ALU_SUB;
      FN_AND:  alu_ctr = ALU_AND;
      FN_OR:   alu_ctr = ALU_OR;
      FN_SLT:  alu_ctr = ALU_SLT;
      default: valid   = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle datapath: fetch/decode/execute/
// memory/writeback sequencing, memory-ready stalls, retire counter.
module multicycle_ctrl
  import cpu_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  multicycle_ctrl_if.master bus
);

  state_t           state_q;
  state_t           state_d;
  state_t           st_out;
  logic [CNT_W-1:0] retired_q;
  logic [3:0]       fn_alu;
  logic             fn_valid;
  logic             op_illegal;
  logic             instr_done;
  logic             illegal_now;
  logic             unused_zero;

  // zero gates the PC load inside the datapath; the controller only raises pcWriteCond
  assign unused_zero = bus.zero;

  alu_op_decode u_alu_op_decode (
    .funct   (bus.funct),
    .alu_ctr (fn_alu),
    .valid   (fn_valid)
  );

  // decode-time legality of the opcode/funct pair
  always_comb begin
    op_illegal = 1'b1;
    case (bus.opcode)
      OP_LW, OP_SW, OP_BEQ, OP_J: op_illegal = 1'b0;
      OP_RTYPE:                   op_illegal = !fn_valid;
      default:                    op_illegal = 1'b1;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // next-state logic; unused encodings recover to FETCH
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:     state_d = bus.memReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (op_illegal)                state_d = S_FETCH;
        else if (bus.opcode == OP_RTYPE) state_d = S_EXECUTE;
        else if (bus.opcode == OP_BEQ)   state_d = S_BRANCH;
        else if (bus.opcode == OP_J)     state_d = S_JUMP;
        else                             state_d = S_MEM_ADDR;
      end
      S_MEM_ADDR:  state_d = (bus.opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  state_d = bus.memReady ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: state_d = bus.memReady ? S_FETCH : S_MEM_WRITE;
      S_EXECUTE:   state_d = S_ALU_WB;
      default:     state_d = S_FETCH;
    endcase
  end

  // Moore outputs; during reset the selects look like FETCH and all strobes are held low
  assign st_out = reset ? S_FETCH : state_q;

  always_comb begin
    bus.aluCtr      = ALU_ADD;
    bus.aluSrcA     = 1'b0;
    bus.aluSrcB     = 2'b00;
    bus.iorD        = 1'b0;
    bus.memRead     = 1'b0;
    bus.memWrite    = 1'b0;
    bus.irWrite     = 1'b0;
    bus.regDst      = 1'b0;
    bus.memToReg    = 1'b0;
    bus.regWrite    = 1'b0;
    bus.pcWrite     = 1'b0;
    bus.pcWriteCond = 1'b0;
    bus.pcSource    = 2'b00;
    instr_done      = 1'b0;
    illegal_now     = 1'b0;
    case (st_out)
      S_FETCH: begin
        bus.memRead = 1'b1;
        bus.aluSrcB = 2'b01;
        bus.irWrite = bus.memReady;
        bus.pcWrite = bus.memReady;
      end
      S_DECODE: begin
        bus.aluSrcB = 2'b11;
        illegal_now = op_illegal;
      end
      S_MEM_ADDR: begin
        bus.aluSrcA = 1'b1;
        bus.aluSrcB = 2'b10;
      end
      S_MEM_READ: begin
        bus.memRead = 1'b1;
        bus.iorD    = 1'b1;
      end
      S_MEM_WB: begin
        bus.regWrite = 1'b1;
        bus.memToReg = 1'b1;
        instr_done   = 1'b1;
      end
      S_MEM_WRITE: begin
        bus.memWrite = 1'b1;
        bus.iorD     = 1'b1;
        instr_done   = bus.memReady;
      end
      S_EXECUTE: begin
        bus.aluSrcA = 1'b1;
        bus.aluCtr  = fn_alu;
      end
      S_ALU_WB: begin
        bus.regWrite = 1'b1;
        bus.regDst   = 1'b1;
        instr_done   = 1'b1;
      end
      S_BRANCH: begin
        bus.aluSrcA     = 1'b1;
        bus.aluCtr      = ALU_SUB;
        bus.pcWriteCond = 1'b1;
        bus.pcSource    = 2'b01;
        instr_done      = 1'b1;
      end
      S_JUMP: begin
        bus.pcWrite  = 1'b1;
        bus.pcSource = 2'b10;
        instr_done   = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      bus.memRead = 1'b0;
      bus.irWrite = 1'b0;
      bus.pcWrite = 1'b0;
    end
  end

  // retired-instruction counter, free-running wrap
  always_ff @(posedge clk) begin
    if (reset)           retired_q <= '0;
    else if (instr_done) retired_q <= retired_q + 1'b1;
  end

  assign bus.instrDone = instr_done;
  assign bus.illegal   = illegal_now;
  assign bus.retired   = retired_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-instruction expected traces built
// from the instruction class, compared against the DUT every cycle.
module tb_multicycle_ctrl;

  localparam int CW = 4;

  typedef struct {
    logic [3:0] st;
    bit         rdy;
    logic [5:0] fn;
    bit         ill;
  } step_t;

  logic clk = 1'b0;
  logic reset;
  step_t q[$];
  int total = 0;
  int bad = 0;
  int model_ret = 0;
  logic [63:0] seq;

  always #5 clk = ~clk;

  multicycle_ctrl_if #(.CNT_W(CW)) bus();

  multicycle_ctrl #(.CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  wire [23:0] dut_vec = {bus.state, bus.aluCtr, bus.aluSrcA, bus.aluSrcB, bus.iorD,
                         bus.memRead, bus.memWrite, bus.irWrite, bus.regDst, bus.memToReg,
                         bus.regWrite, bus.pcWrite, bus.pcWriteCond, bus.pcSource,
                         bus.instrDone, bus.illegal};

  // expected control word for a state, straight from the per-state output table
  function automatic logic [23:0] exp_vec(logic [3:0] s, bit rdy, logic [5:0] fn, bit ill, bit in_rst);
    logic [3:0] alu = 4'b0010;
    logic       a = 0, iord = 0, mr = 0, mw = 0, ir = 0, rd = 0, m2r = 0, rw = 0, pcw = 0, pcwc = 0;
    logic [1:0] b = 2'b00, pcs = 2'b00;
    logic       done = 0, il = 0;
    if (in_rst) b = 2'b01;
    else begin
      case (s)
        4'd0: begin mr = 1; b = 2'b01; ir = rdy; pcw = rdy; end
        4'd1: begin b = 2'b11; il = ill; end
        4'd2: begin a = 1; b = 2'b10; end
        4'd3: begin mr = 1; iord = 1; end
        4'd4: begin rw = 1; m2r = 1; done = 1; end
        4'd5: begin mw = 1; iord = 1; done = rdy; end
        4'd6: begin
          a = 1;
          case (fn)
            6'b100000: alu = 4'b0010;
            6'b100010: alu = 4'b0110;
            6'b100100: alu = 4'b0000;
            6'b100101: alu = 4'b0001;
            6'b101010: alu = 4'b0111;
            default:   alu = 4'b0010;
          endcase
        end
        4'd7: begin rw = 1; rd = 1; done = 1; end
        4'd8: begin a = 1; alu = 4'b0110; pcwc = 1; pcs = 2'b01; done = 1; end
        4'd9: begin pcw = 1; pcs = 2'b10; done = 1; end
        default: ;
      endcase
    end
    return {s, alu, a, b, iord, mr, mw, ir, rd, m2r, rw, pcw, pcwc, pcs, done, il};
  endfunction

  // instruction class: 0 illegal, 1 lw, 2 sw, 3 R-type, 4 beq, 5 j
  function automatic int kind(logic [5:0] op, logic [5:0] fn);
    case (op)
      6'b100011: return 1;
      6'b101011: return 2;
      6'b000100: return 4;
      6'b000010: return 5;
      6'b000000: return (fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010}) ? 3 : 0;
      default:   return 0;
    endcase
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(logic [3:0] s, bit rdy, logic [5:0] fn, bit ill);
    step_t e;
    e.st = s; e.rdy = rdy; e.fn = fn; e.ill = ill;
    q.push_back(e);
  endtask

  // expected trace of one instruction with given FETCH and memory-stage stalls
  task automatic plan(logic [5:0] op, logic [5:0] fn, int fst, int mst);
    int k = kind(op, fn);
    bus.opcode = op;
    bus.funct  = fn;
    repeat (fst) push(4'd0, 1'b0, fn, 1'b0);
    push(4'd0, 1'b1, fn, 1'b0);
    push(4'd1, 1'($urandom_range(0, 1)), fn, k == 0);
    case (k)
      1: begin
        push(4'd2, 1'($urandom_range(0, 1)), fn, 1'b0);
        repeat (mst) push(4'd3, 1'b0, fn, 1'b0);
        push(4'd3, 1'b1, fn, 1'b0);
        push(4'd4, 1'($urandom_range(0, 1)), fn, 1'b0);
      end
      2: begin
        push(4'd2, 1'($urandom_range(0, 1)), fn, 1'b0);
        repeat (mst) push(4'd5, 1'b0, fn, 1'b0);
        push(4'd5, 1'b1, fn, 1'b0);
      end
      3: begin
        push(4'd6, 1'($urandom_range(0, 1)), fn, 1'b0);
        push(4'd7, 1'($urandom_range(0, 1)), fn, 1'b0);
      end
      4: push(4'd8, 1'($urandom_range(0, 1)), fn, 1'b0);
      5: push(4'd9, 1'($urandom_range(0, 1)), fn, 1'b0);
      default: ;
    endcase
  endtask

  // drive one step per cycle, compare at the falling edge, advance the retire model
  task automatic run_queue(string name);
    step_t e;
    logic [23:0] v;
    while (q.size() > 0) begin
      e = q.pop_front();
      bus.memReady = e.rdy;
      bus.zero     = 1'($urandom_range(0, 1));
      v = exp_vec(e.st, e.rdy, e.fn, e.ill, 1'b0);
      @(negedge clk);
      check({name, " ctrl"}, 64'(dut_vec), 64'(v));
      check({name, " retired"}, 64'(bus.retired), 64'(model_ret));
      seq = {seq[59:0], bus.state};
      @(posedge clk);
      #1;
      if (v[1]) model_ret = (model_ret + 1) % (1 << CW);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [5:0] rfn [4];
    rfn[0] = 6'b100000; rfn[1] = 6'b100100; rfn[2] = 6'b100101; rfn[3] = 6'b101010;

    reset = 1'b1;
    bus.memReady = 1'b1;
    bus.opcode = 6'b000000;
    bus.funct  = 6'b100010;
    bus.zero   = 1'b0;
    @(posedge clk);
    #1;
    repeat (3) begin
      @(negedge clk);
      check("reset ctrl", 64'(dut_vec), 64'(exp_vec(4'd0, 1'b1, 6'd0, 1'b0, 1'b1)));
      check("reset retired", 64'(bus.retired), 64'd0);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;

    seq = '0;
    plan(6'b000000, 6'b100010, 0, 0);
    run_queue("rsub");
    check("rsub seq", seq, 64'h0167);
    check("rsub back to fetch", 64'(bus.state), 64'd0);
    check("rsub retired", 64'(bus.retired), 64'd1);

    for (int i = 0; i < 4; i++) begin
      plan(6'b000000, rfn[i], 0, 0);
      run_queue("rtype");
    end

    seq = '0;
    plan(6'b100011, 6'b000000, 0, 2);
    run_queue("lw");
    check("lw seq", seq, 64'h0123334);

    seq = '0;
    plan(6'b101011, 6'b000000, 1, 0);
    run_queue("sw");
    check("sw seq", seq, 64'h00125);

    seq = '0;
    plan(6'b000100, 6'b000000, 0, 0);
    run_queue("beq");
    check("beq seq", seq, 64'h018);

    seq = '0;
    plan(6'b111111, 6'b000000, 0, 0);
    run_queue("ill op");
    plan(6'b000000, 6'b000000, 0, 0);
    run_queue("ill fn");
    check("illegal seq", seq, 64'h0101);
    check("illegal retired", 64'(bus.retired), 64'd8);

    plan(6'b000010, 6'b000000, 0, 0);
    run_queue("j");
    check("j retired", 64'(bus.retired), 64'd9);

    bus.opcode = 6'b101011;
    push(4'd0, 1'b1, 6'd0, 1'b0);
    push(4'd1, 1'b0, 6'd0, 1'b0);
    push(4'd2, 1'b1, 6'd0, 1'b0);
    push(4'd5, 1'b0, 6'd0, 1'b0);
    run_queue("sw abort");
    reset = 1'b1;
    bus.memReady = 1'b1;
    @(negedge clk);
    check("abort ctrl", 64'(dut_vec), 64'(exp_vec(4'd5, 1'b1, 6'd0, 1'b0, 1'b1)));
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.memReady = 1'b0;
    model_ret = 0;
    @(negedge clk);
    check("abort state", 64'(bus.state), 64'd0);
    check("abort retired", 64'(bus.retired), 64'd0);
    @(posedge clk);
    #1;

    repeat (15) begin
      plan(6'b000010, 6'b000000, 0, 0);
      run_queue("jfill");
    end
    check("wrap max", 64'(bus.retired), 64'd15);
    plan(6'b000010, 6'b000000, 0, 0);
    run_queue("jwrap");
    check("wrap zero", 64'(bus.retired), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
